// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port among NREQ writeback requesters.
//   A combinational round-robin arbiter raises req_ready for one valid requester;
//   the accepted write is registered and presented to the register file on the
//   following cycle. Writes to address 0 are accepted but dropped (x0_drop pulse).
//   Saturating statistics count commits and multi-requester contention cycles.
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req_valid     per-requester pending write
//   req_addr      requester i address at [i*AW +: AW]
//   req_data      requester i data at [i*DW +: DW]
//   req_ready     one-hot (or zero) grant, forced low while rst=1
//   Wt_addr       registered write address
//   Wt_data       registered write data
//   RegWrite      registered write enable (forced low while rst=1)
//   grant_id      index of the last accepted requester
//   x0_drop       one-cycle pulse when an accepted write targeted address 0
//   commit_cnt    RegWrite cycles since reset, saturating
//   conflict_cnt  non-reset cycles with two or more valid requesters, saturating
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      Wt_addr,
  output logic [DW-1:0]      Wt_data,
  output logic               RegWrite,
  output logic [2:0]         grant_id,
  output logic               x0_drop,
  output logic [CW-1:0]      commit_cnt,
  output logic [CW-1:0]      conflict_cnt
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // True when at least two bits are set: clearing the lowest set bit leaves something.
  function automatic logic multi_valid(input logic [NREQ-1:0] v);
    multi_valid = ((v & (v - {{(NREQ-1){1'b0}}, 1'b1})) != {NREQ{1'b0}});
  endfunction

  logic [AW-1:0] wt_addr_q, wt_addr_d;
  logic [DW-1:0] wt_data_q, wt_data_d;
  logic          regwrite_q, regwrite_d;
  logic          x0_drop_q, x0_drop_d;
  logic [2:0]    grant_id_q, grant_id_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] commit_cnt_q, commit_cnt_d;
  logic [CW-1:0] conflict_cnt_q, conflict_cnt_d;

  logic          grant_found_s;
  logic [2:0]    grant_idx_s;
  logic          accept_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_data_s;
  logic          regwrite_s;

  // Round-robin search: walk offsets from the highest down so the smallest
  // offset from rr_ptr that is valid is the one left standing.
  always_comb begin
    int idx;
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (req_valid[idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = 3'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot ready for the winner; nothing can be accepted during reset.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_found_s && !rst && (grant_idx_s == 3'(i));
    end
  end

  // Winner's address/data mux.
  always_comb begin
    sel_addr_s = req_addr[int'(grant_idx_s)*AW +: AW];
    sel_data_s = req_data[int'(grant_idx_s)*DW +: DW];
  end

  // Registered outputs; the enable and drop pulse are masked during reset so
  // an accept registered just before reset never reaches the register file.
  always_comb begin
    accept_s     = grant_found_s && !rst;
    regwrite_s   = regwrite_q && !rst;
    RegWrite     = regwrite_s;
    x0_drop      = x0_drop_q && !rst;
    Wt_addr      = wt_addr_q;
    Wt_data      = wt_data_q;
    grant_id     = grant_id_q;
    commit_cnt   = commit_cnt_q;
    conflict_cnt = conflict_cnt_q;
  end

  // Next-state for the commit stage, pointer and statistics.
  always_comb begin
    wt_addr_d      = wt_addr_q;
    wt_data_d      = wt_data_q;
    grant_id_d     = grant_id_q;
    rr_ptr_d       = rr_ptr_q;
    regwrite_d     = 1'b0;
    x0_drop_d      = 1'b0;
    commit_cnt_d   = commit_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (accept_s) begin
      wt_addr_d  = sel_addr_s;
      wt_data_d  = sel_data_s;
      grant_id_d = grant_idx_s;
      regwrite_d = (sel_addr_s != {AW{1'b0}});
      x0_drop_d  = (sel_addr_s == {AW{1'b0}});
      if (int'(grant_idx_s) == NREQ - 1) begin
        rr_ptr_d = 3'd0;
      end else begin
        rr_ptr_d = grant_idx_s + 3'd1;
      end
    end else begin
      regwrite_d = 1'b0;
      x0_drop_d  = 1'b0;
    end
    if (regwrite_s) begin
      commit_cnt_d = sat_inc(commit_cnt_q);
    end else begin
      commit_cnt_d = commit_cnt_q;
    end
    if (multi_valid(req_valid)) begin
      conflict_cnt_d = sat_inc(conflict_cnt_q);
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_addr_q      <= {AW{1'b0}};
      wt_data_q      <= {DW{1'b0}};
      regwrite_q     <= 1'b0;
      x0_drop_q      <= 1'b0;
      grant_id_q     <= 3'd0;
      rr_ptr_q       <= 3'd0;
      commit_cnt_q   <= {CW{1'b0}};
      conflict_cnt_q <= {CW{1'b0}};
    end else begin
      wt_addr_q      <= wt_addr_d;
      wt_data_q      <= wt_data_d;
      regwrite_q     <= regwrite_d;
      x0_drop_q      <= x0_drop_d;
      grant_id_q     <= grant_id_d;
      rr_ptr_q       <= rr_ptr_d;
      commit_cnt_q   <= commit_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

endmodule
